// File: rtl/kyo_hit_anim_ctrl_if.sv
// rtl/kyo_hit_anim_ctrl_if.sv - scan/trigger inputs and sprite address outputs of the Kyo hit animation
// Signals:
//   vsync                          VGA vsync (active-low, rising edge = frame boundary)
//   trigger, flip                  start request and horizontal mirror select
//   pos_x, pos_y                   sprite top-left corner in screen pixels
//   draw_x, draw_y                 current scan position
//   rom_address                    registered sprite ROM address
//   sprite_on, frame_idx           in-box flag and current frame
//   busy, done                     playing flag and end-of-animation pulse
// Modports: master drives inputs / observes outputs; slave is the controller.
interface kyo_hit_anim_ctrl_if;
    logic        vsync;
    logic        trigger;
    logic        flip;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [13:0] rom_address;
    logic        sprite_on;
    logic [1:0]  frame_idx;
    logic        busy;
    logic        done;

    modport master (
        output vsync, trigger, flip, pos_x, pos_y, draw_x, draw_y,
        input  rom_address, sprite_on, frame_idx, busy, done
    );

    modport slave (
        input  vsync, trigger, flip, pos_x, pos_y, draw_x, draw_y,
        output rom_address, sprite_on, frame_idx, busy, done
    );
endinterface

// File: rtl/kyo_hit_anim_ctrl.sv
// rtl/kyo_hit_anim_ctrl.sv - Kyo hit-reaction animation sequencer and sprite ROM address generator
// Ports:
//   vga_clk   pixel clock, all logic on posedge
//   reset     synchronous active-high reset
//   bus       kyo_hit_anim_ctrl_if.slave (scan position, trigger, ROM address, status)
module kyo_hit_anim_ctrl #(
    parameter int FRAME_W     = 64,
    parameter int FRAME_H     = 64,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 6,
    parameter int RETRIGGER   = 1
) (
    input  logic                vga_clk,
    input  logic                reset,
    kyo_hit_anim_ctrl_if.slave  bus
);
    localparam int TICK_W = $clog2(FRAME_TICKS + 1);

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          frame_q, frame_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                flip_q, flip_d;
    logic                vsync_q;
    logic                done_q, done_d;
    logic [13:0]         rom_address_q, rom_address_d;
    logic                sprite_on_q, sprite_on_d;

    logic                tick;
    logic                busy;
    logic [10:0]         dx, dy, col;
    logic                in_box;
    logic [13:0]         addr;

    // Rising edge of the active-low vsync pulse marks the end of a displayed frame.
    assign tick = bus.vsync & ~vsync_q;
    assign busy = (state_q == PLAY);

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        tick_cnt_d = tick_cnt_q;
        flip_d     = flip_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // A tick coinciding with the trigger is not counted.
                if (bus.trigger) begin
                    state_d    = PLAY;
                    frame_d    = '0;
                    tick_cnt_d = '0;
                    flip_d     = bus.flip;
                end
            end
            PLAY: begin
                // Restart has priority over the final tick, so no done pulse then.
                if (bus.trigger && (RETRIGGER != 0)) begin
                    frame_d    = '0;
                    tick_cnt_d = '0;
                    flip_d     = bus.flip;
                end else if (tick) begin
                    if (tick_cnt_q < TICK_W'(FRAME_TICKS - 1)) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end else begin
                        tick_cnt_d = '0;
                        if (frame_q < 2'(NUM_FRAMES - 1)) begin
                            frame_d = frame_q + 1'b1;
                        end else begin
                            state_d = IDLE;
                            frame_d = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address path: the 11-bit differences go negative (bit 10 set) left of /
    // above the sprite, so the box test never wraps around the screen edge.
    always_comb begin
        dx            = {1'b0, bus.draw_x} - {1'b0, bus.pos_x};
        dy            = {1'b0, bus.draw_y} - {1'b0, bus.pos_y};
        in_box        = !dx[10] && (dx < 11'(FRAME_W)) && !dy[10] && (dy < 11'(FRAME_H));
        col           = flip_q ? (11'(FRAME_W - 1) - dx) : dx;
        addr          = 14'(frame_q) * 14'(FRAME_W * FRAME_H)
                      + 14'(dy) * 14'(FRAME_W) + 14'(col);
        rom_address_d = in_box ? addr : 14'd0;
        sprite_on_d   = in_box & busy;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            tick_cnt_q    <= '0;
            flip_q        <= 1'b0;
            vsync_q       <= 1'b0;
            done_q        <= 1'b0;
            rom_address_q <= '0;
            sprite_on_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            tick_cnt_q    <= tick_cnt_d;
            flip_q        <= flip_d;
            vsync_q       <= bus.vsync;
            done_q        <= done_d;
            rom_address_q <= rom_address_d;
            sprite_on_q   <= sprite_on_d;
        end
    end

    assign bus.rom_address = rom_address_q;
    assign bus.sprite_on   = sprite_on_q;
    assign bus.frame_idx   = frame_q;
    assign bus.busy        = busy;
    assign bus.done        = done_q;
endmodule
